// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures the memory word into the
// instruction register, and handles stalls, redirects and the halt instruction.
module fetch_unit #(
  parameter logic [7:0] RESET_PC   = 8'd0,
  parameter logic [7:0] HALT_INSTR = 8'b1111_1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  instruction,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  address,
  output logic [7:0]  ir,
  output logic [7:0]  ir_pc,
  output logic        valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state, state_nxt;
  logic [7:0]  address_nxt, ir_nxt, ir_pc_nxt;
  logic        valid_nxt;
  logic [15:0] count_nxt;

  always_comb begin
    state_nxt   = state;
    address_nxt = address;
    ir_nxt      = ir;
    ir_pc_nxt   = ir_pc;
    valid_nxt   = valid;
    count_nxt   = fetch_count;
    case (state)
      FETCH: begin
        if (redirect) begin
          address_nxt = redirect_pc;
          valid_nxt   = 1'b0;
        end else if (!stall) begin
          ir_nxt    = instruction;
          ir_pc_nxt = address;
          valid_nxt = 1'b1;
          if (fetch_count != 16'hFFFF)
            count_nxt = fetch_count + 16'd1;
          if (instruction == HALT_INSTR)
            state_nxt = HALTED;
          else
            address_nxt = address + 8'd1;
        end
      end
      HALTED: begin
        // Halt word is presented until decode takes it, then fetch goes quiet.
        if (!stall)
          valid_nxt = 1'b0;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      address     <= RESET_PC;
      ir          <= '0;
      ir_pc       <= '0;
      valid       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      address     <= address_nxt;
      ir          <= ir_nxt;
      ir_pc       <= ir_pc_nxt;
      valid       <= valid_nxt;
      fetch_count <= count_nxt;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios plus
// randomized traffic against a behavioural fetch model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  instruction;
  logic        stall;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  address;
  logic [7:0]  ir;
  logic [7:0]  ir_pc;
  logic        valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0] mem [256];
  assign instruction = mem[address];

  fetch_unit #(.RESET_PC(8'd0), .HALT_INSTR(8'hFF)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .address(address),
    .ir(ir), .ir_pc(ir_pc), .valid(valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: architectural view of the fetch stage
  logic [7:0]  m_pc, m_ir, m_irpc;
  logic        m_valid, m_halt;
  int unsigned m_cnt;

  function automatic logic [41:0] obs_vec();
    return {address, ir, ir_pc, valid, halted, fetch_count};
  endfunction

  function automatic logic [41:0] model_vec();
    return {m_pc, m_ir, m_irpc, m_valid, m_halt, m_cnt[15:0]};
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic d, input logic [7:0] t);
    if (r) begin
      m_pc = 8'd0; m_ir = 8'd0; m_irpc = 8'd0; m_valid = 0; m_halt = 0; m_cnt = 0;
    end else if (m_halt) begin
      if (!s) m_valid = 0;
    end else if (d) begin
      m_pc = t; m_valid = 0;
    end else if (!s) begin
      m_ir = mem[m_pc]; m_irpc = m_pc; m_valid = 1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (mem[m_pc] == 8'hFF) m_halt = 1;
      else m_pc = 8'((m_pc + 9'd1) % 256);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic d, input logic [7:0] t);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    @(posedge clk);
    model_edge(r, s, d, t);
    #1;
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    mem[9] = 8'hFF;
  endtask

  task automatic test_reset();
    load_ramp();
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'h33);
    tests++;
    if (obs_vec() !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL reset: got %h required %h", obs_vec(), {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000});
    end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 8'h00);
      tests++;
      if (ir !== 8'(k + 15) || ir_pc !== 8'(k - 1) || valid !== 1'b1 ||
          fetch_count !== 16'(k) || address !== 8'(k)) begin
        fails++;
        $display("FAIL sequential[%0d]: got ir=%h ir_pc=%h valid=%b cnt=%0d addr=%h required ir=%h ir_pc=%h valid=1 cnt=%0d addr=%h",
                 k, ir, ir_pc, valid, fetch_count, address, 8'(k + 15), 8'(k - 1), k, 8'(k));
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 8'h00);
      tests++;
      if (ir !== 8'h14 || ir_pc !== 8'h04 || valid !== 1'b1 ||
          address !== 8'h05 || fetch_count !== 16'd5) begin
        fails++;
        $display("FAIL stall[%0d]: got ir=%h ir_pc=%h valid=%b addr=%h cnt=%0d required 14 04 1 05 5",
                 k, ir, ir_pc, valid, address, fetch_count);
      end
    end
    step(0, 0, 0, 8'h00);
    tests++;
    if (ir_pc !== 8'h05 || ir !== 8'h15 || fetch_count !== 16'd6) begin
      fails++;
      $display("FAIL stall_resume: got ir=%h ir_pc=%h cnt=%0d required 15 05 6", ir, ir_pc, fetch_count);
    end
  endtask

  task automatic test_redirect();
    step(0, 1, 1, 8'h40);
    tests++;
    if (valid !== 1'b0 || address !== 8'h40 || fetch_count !== 16'd6 || ir_pc !== 8'h05) begin
      fails++;
      $display("FAIL redirect_bubble: got valid=%b addr=%h cnt=%0d ir_pc=%h required 0 40 6 05",
               valid, address, fetch_count, ir_pc);
    end
    step(0, 0, 0, 8'h00);
    tests++;
    if (ir !== 8'h50 || ir_pc !== 8'h40 || valid !== 1'b1 || fetch_count !== 16'd7) begin
      fails++;
      $display("FAIL redirect_target: got ir=%h ir_pc=%h valid=%b cnt=%0d required 50 40 1 7",
               ir, ir_pc, valid, fetch_count);
    end
  endtask

  task automatic test_halt();
    step(0, 0, 1, 8'h07);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    tests++;
    if (ir !== 8'hFF || ir_pc !== 8'h09 || valid !== 1'b1 || halted !== 1'b1 ||
        address !== 8'h09 || fetch_count !== 16'd10) begin
      fails++;
      $display("FAIL halt_latch: got ir=%h ir_pc=%h valid=%b halted=%b addr=%h cnt=%0d required ff 09 1 1 09 10",
               ir, ir_pc, valid, halted, address, fetch_count);
    end
    step(0, 0, 0, 8'h00);
    tests++;
    if (valid !== 1'b0 || halted !== 1'b1 || address !== 8'h09) begin
      fails++;
      $display("FAIL halt_drain: got valid=%b halted=%b addr=%h required 0 1 09", valid, halted, address);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 1'(k & 1), 1, 8'h00);
      tests++;
      if (valid !== 1'b0 || halted !== 1'b1 || address !== 8'h09 ||
          ir !== 8'hFF || fetch_count !== 16'd10) begin
        fails++;
        $display("FAIL halt_frozen[%0d]: got valid=%b halted=%b addr=%h ir=%h cnt=%0d required 0 1 09 ff 10",
                 k, valid, halted, address, ir, fetch_count);
      end
    end
    step(1, 0, 0, 8'h00);
    tests++;
    if (obs_vec() !== {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL halt_reset: got %h required %h", obs_vec(), {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000});
    end
  endtask

  task automatic test_wrong_path();
    step(0, 0, 1, 8'h08);
    step(0, 0, 0, 8'h00);
    tests++;
    if (ir_pc !== 8'h08 || address !== 8'h09 || instruction !== 8'hFF) begin
      fails++;
      $display("FAIL wrong_path_setup: got ir_pc=%h addr=%h instr=%h required 08 09 ff", ir_pc, address, instruction);
    end
    step(0, 0, 1, 8'h20);
    tests++;
    if (halted !== 1'b0 || address !== 8'h20 || valid !== 1'b0) begin
      fails++;
      $display("FAIL wrong_path_flush: got halted=%b addr=%h valid=%b required 0 20 0", halted, address, valid);
    end
    step(0, 0, 0, 8'h00);
    tests++;
    if (ir !== 8'h30 || ir_pc !== 8'h20 || valid !== 1'b1 || halted !== 1'b0) begin
      fails++;
      $display("FAIL wrong_path_resume: got ir=%h ir_pc=%h valid=%b halted=%b required 30 20 1 0",
               ir, ir_pc, valid, halted);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    step(0, 0, 1, 8'hFE);
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 8'h00);
      want = 8'((254 + j) % 256);
      tests++;
      if (ir_pc !== want || valid !== 1'b1 || ir !== 8'((want + 16) % 256)) begin
        fails++;
        $display("FAIL wrap[%0d]: got ir_pc=%h valid=%b ir=%h required ir_pc=%h valid=1 ir=%h",
                 j, ir_pc, valid, ir, want, 8'((want + 16) % 256));
      end
    end
  endtask

  task automatic test_random();
    int unsigned bad = 0;
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 39) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    step(1, 0, 0, 8'h00);
    for (int c = 0; c < 2000; c++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), 8'($urandom));
      tests++;
      if (obs_vec() !== model_vec()) begin
        fails++;
        if (bad < 10)
          $display("FAIL random[%0d]: got {addr,ir,ir_pc,valid,halted,cnt}=%h required %h",
                   c, obs_vec(), model_vec());
        bad++;
      end
    end
  endtask

  task automatic test_model_agree();
    tests++;
    if (obs_vec() !== model_vec()) begin
      fails++;
      $display("FAIL model_agree: got %h required %h", obs_vec(), model_vec());
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    m_pc = 8'd0; m_ir = 8'd0; m_irpc = 8'd0; m_valid = 0; m_halt = 0; m_cnt = 0;
    load_ramp();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_model_agree();
    test_halt();
    test_wrong_path();
    test_wrap();
    test_model_agree();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
